otter_id_ex_reg: RTL and testbench

- ID/EX pipeline register and load-use hazard unit for the OTTER 5-stage RV32I pipeline.
- Captures the decode-stage control fields (ALU_SRCA/SRCB/FUN, RF_WR_SEL) plus PC, IR and operand data, and presents them to Execute one cycle later.
- Detects load-use hazards, stalls IF/ID and inserts bubbles.
- Honours branch/jump flushes from Execute and whole-pipe stalls from Memory.

---
 rtl/otter_id_ex_reg.sv | 210 +++++++++++++++++++++
 tb/tb_otter_id_ex_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_id_ex_reg.sv
// otter_id_ex_reg: ID/EX pipeline register with load-use hazard detection
// for the OTTER 5-stage RV32I pipeline.
// Optional performance counters are enabled by defining OTTER_ID_EX_PERF_EN.
module otter_id_ex_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ID_VALID,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [31:0]     ID_IR,
  input  logic [XLEN-1:0] ID_RS1,
  input  logic [XLEN-1:0] ID_RS2,
  input  logic            ID_ALU_SRCA,
  input  logic [1:0]      ID_ALU_SRCB,
  input  logic [3:0]      ID_ALU_FUN,
  input  logic [1:0]      ID_RF_WR_SEL,
  input  logic            EX_FLUSH,
  input  logic            MEM_STALL,
  output logic            ID_STALL,
  output logic            EX_VALID,
  output logic [XLEN-1:0] EX_PC,
  output logic [31:0]     EX_IR,
  output logic [XLEN-1:0] EX_RS1,
  output logic [XLEN-1:0] EX_RS2,
  output logic            EX_ALU_SRCA,
  output logic [1:0]      EX_ALU_SRCB,
  output logic [3:0]      EX_ALU_FUN,
  output logic [1:0]      EX_RF_WR_SEL,
  output logic            EX_REG_WR,
  output logic            EX_MEM_WE,
  output logic            EX_MEM_RE,
`ifdef OTTER_ID_EX_PERF_EN
  output logic [31:0]     PERF_BUBBLES,
  output logic [31:0]     PERF_FLUSHES,
`endif
  output logic [4:0]      EX_RD
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic            ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0] ex_pc_q,       ex_pc_d;
  logic [31:0]     ex_ir_q,       ex_ir_d;
  logic [XLEN-1:0] ex_rs1_q,      ex_rs1_d;
  logic [XLEN-1:0] ex_rs2_q,      ex_rs2_d;
  logic            ex_alu_srca_q, ex_alu_srca_d;
  logic [1:0]      ex_alu_srcb_q, ex_alu_srcb_d;
  logic [3:0]      ex_alu_fun_q,  ex_alu_fun_d;
  logic [1:0]      ex_rf_wr_sel_q, ex_rf_wr_sel_d;
  logic            ex_reg_wr_q,   ex_reg_wr_d;
  logic            ex_mem_we_q,   ex_mem_we_d;
  logic            ex_mem_re_q,   ex_mem_re_d;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2, ex_rd;
  logic [2:0] funct3;
  logic       uses_rs1, uses_rs2;
  logic       dec_reg_wr, dec_mem_we, dec_mem_re;
  logic       hz, load_bubble;

  // Decode the ID instruction and detect a load in EX feeding one of its sources.
  always_comb begin
    opcode   = ID_IR[6:0];
    rd       = ID_IR[11:7];
    funct3   = ID_IR[14:12];
    rs1      = ID_IR[19:15];
    rs2      = ID_IR[24:20];
    ex_rd    = ex_ir_q[11:7];
    uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    uses_rs2 = (opcode == OP_OP) || (opcode == OP_BRANCH) || (opcode == OP_STORE);
    // ecall/ebreak/mret (SYSTEM, funct3==0) never write rd; CSR ops do.
    dec_reg_wr = ID_VALID && (rd != 5'd0) && (opcode != OP_BRANCH) && (opcode != OP_STORE)
                 && !((opcode == OP_SYSTEM) && (funct3 == 3'd0));
    dec_mem_we = ID_VALID && (opcode == OP_STORE);
    dec_mem_re = ID_VALID && (opcode == OP_LOAD);
    hz = ID_VALID && ex_valid_q && ex_mem_re_q && (ex_rd != 5'd0)
         && ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    // A flush already discards the ID instruction, so no need to hold it.
    ID_STALL    = MEM_STALL || (hz && !EX_FLUSH);
    load_bubble = !MEM_STALL && !EX_FLUSH && hz;
  end

  // Next EX slot: hold on downstream stall, bubble on flush or load-use, else capture.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_ir_d        = ex_ir_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_alu_srca_d  = ex_alu_srca_q;
    ex_alu_srcb_d  = ex_alu_srcb_q;
    ex_alu_fun_d   = ex_alu_fun_q;
    ex_rf_wr_sel_d = ex_rf_wr_sel_q;
    ex_reg_wr_d    = ex_reg_wr_q;
    ex_mem_we_d    = ex_mem_we_q;
    ex_mem_re_d    = ex_mem_re_q;
    if (!MEM_STALL) begin
      if (EX_FLUSH || hz) begin
        ex_valid_d     = 1'b0;
        ex_pc_d        = '0;
        ex_ir_d        = NOP_INSTR;
        ex_rs1_d       = '0;
        ex_rs2_d       = '0;
        ex_alu_srca_d  = 1'b0;
        ex_alu_srcb_d  = '0;
        ex_alu_fun_d   = '0;
        ex_rf_wr_sel_d = '0;
        ex_reg_wr_d    = 1'b0;
        ex_mem_we_d    = 1'b0;
        ex_mem_re_d    = 1'b0;
      end else begin
        ex_valid_d     = ID_VALID;
        ex_pc_d        = ID_PC;
        ex_ir_d        = ID_IR;
        ex_rs1_d       = ID_RS1;
        ex_rs2_d       = ID_RS2;
        ex_alu_srca_d  = ID_ALU_SRCA;
        ex_alu_srcb_d  = ID_ALU_SRCB;
        ex_alu_fun_d   = ID_ALU_FUN;
        ex_rf_wr_sel_d = ID_RF_WR_SEL;
        ex_reg_wr_d    = dec_reg_wr;
        ex_mem_we_d    = dec_mem_we;
        ex_mem_re_d    = dec_mem_re;
      end
    end
  end

  // EX slot register; reset state equals a bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_ir_q        <= NOP_INSTR;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_alu_srca_q  <= 1'b0;
      ex_alu_srcb_q  <= '0;
      ex_alu_fun_q   <= '0;
      ex_rf_wr_sel_q <= '0;
      ex_reg_wr_q    <= 1'b0;
      ex_mem_we_q    <= 1'b0;
      ex_mem_re_q    <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_ir_q        <= ex_ir_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_alu_srca_q  <= ex_alu_srca_d;
      ex_alu_srcb_q  <= ex_alu_srcb_d;
      ex_alu_fun_q   <= ex_alu_fun_d;
      ex_rf_wr_sel_q <= ex_rf_wr_sel_d;
      ex_reg_wr_q    <= ex_reg_wr_d;
      ex_mem_we_q    <= ex_mem_we_d;
      ex_mem_re_q    <= ex_mem_re_d;
    end
  end

`ifdef OTTER_ID_EX_PERF_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  // Count load-use bubbles and flush edges; both freeze while the pipe is stalled.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q + (load_bubble ? 32'd1 : 32'd0);
    perf_flushes_d = perf_flushes_q + ((!MEM_STALL && EX_FLUSH) ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign PERF_BUBBLES = perf_bubbles_q;
  assign PERF_FLUSHES = perf_flushes_q;
`else
  logic unused_load_bubble;
  assign unused_load_bubble = load_bubble;
`endif

  assign EX_VALID     = ex_valid_q;
  assign EX_PC        = ex_pc_q;
  assign EX_IR        = ex_ir_q;
  assign EX_RS1       = ex_rs1_q;
  assign EX_RS2       = ex_rs2_q;
  assign EX_ALU_SRCA  = ex_alu_srca_q;
  assign EX_ALU_SRCB  = ex_alu_srcb_q;
  assign EX_ALU_FUN   = ex_alu_fun_q;
  assign EX_RF_WR_SEL = ex_rf_wr_sel_q;
  assign EX_REG_WR    = ex_reg_wr_q;
  assign EX_MEM_WE    = ex_mem_we_q;
  assign EX_MEM_RE    = ex_mem_re_q;
  assign EX_RD        = ex_rd;

endmodule

// File: tb/tb_otter_id_ex_reg.sv
// Testbench for otter_id_ex_reg: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the EX slot.
// Also exercises the counters when OTTER_ID_EX_PERF_EN is defined.
module tb_otter_id_ex_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        RST, ID_VALID, ID_ALU_SRCA, EX_FLUSH, MEM_STALL;
  logic [31:0] ID_PC, ID_IR, ID_RS1, ID_RS2;
  logic [1:0]  ID_ALU_SRCB, ID_RF_WR_SEL;
  logic [3:0]  ID_ALU_FUN;
  logic        ID_STALL, EX_VALID, EX_ALU_SRCA, EX_REG_WR, EX_MEM_WE, EX_MEM_RE;
  logic [31:0] EX_PC, EX_IR, EX_RS1, EX_RS2;
  logic [1:0]  EX_ALU_SRCB, EX_RF_WR_SEL;
  logic [3:0]  EX_ALU_FUN;
  logic [4:0]  EX_RD;
`ifdef OTTER_ID_EX_PERF_EN
  logic [31:0] PERF_BUBBLES, PERF_FLUSHES;
`endif

  always #5 clk = ~clk;

  otter_id_ex_reg dut (
    .CLK(clk), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_IR(ID_IR),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_ALU_SRCA(ID_ALU_SRCA),
    .ID_ALU_SRCB(ID_ALU_SRCB), .ID_ALU_FUN(ID_ALU_FUN), .ID_RF_WR_SEL(ID_RF_WR_SEL),
    .EX_FLUSH(EX_FLUSH), .MEM_STALL(MEM_STALL), .ID_STALL(ID_STALL),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IR(EX_IR), .EX_RS1(EX_RS1),
    .EX_RS2(EX_RS2), .EX_ALU_SRCA(EX_ALU_SRCA), .EX_ALU_SRCB(EX_ALU_SRCB),
    .EX_ALU_FUN(EX_ALU_FUN), .EX_RF_WR_SEL(EX_RF_WR_SEL), .EX_REG_WR(EX_REG_WR),
    .EX_MEM_WE(EX_MEM_WE), .EX_MEM_RE(EX_MEM_RE),
`ifdef OTTER_ID_EX_PERF_EN
    .PERF_BUBBLES(PERF_BUBBLES), .PERF_FLUSHES(PERF_FLUSHES),
`endif
    .EX_RD(EX_RD)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc, ir, rs1, rs2;
    logic        srca;
    logic [1:0]  srcb;
    logic [3:0]  fun;
    logic [1:0]  wsel;
    logic        rw, we, re;
  } ex_t;

  ex_t         m;
  int unsigned m_bubbles, m_flushes;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int f3,
                                     input int rs1, input int rs2);
    logic [31:0] w;
    w = '0;
    w[6:0]   = op;
    w[11:7]  = rd[4:0];
    w[14:12] = f3[2:0];
    w[19:15] = rs1[4:0];
    w[24:20] = rs2[4:0];
    return w;
  endfunction

  function automatic ex_t bubble();
    ex_t b;
    b = '0;
    b.ir = NOP;
    return b;
  endfunction

  // Reference: which source registers an instruction reads, and its side effects.
  function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] r);
    logic [6:0] op;
    op = ir[6:0];
    if (op != 7'h37 && op != 7'h17 && op != 7'h6f && ir[19:15] == r) return 1'b1;
    if ((op == 7'h33 || op == 7'h63 || op == 7'h23) && ir[24:20] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_hz();
    return ID_VALID && m.v && m.re && m.ir[11:7] != 5'd0 && reads_reg(ID_IR, m.ir[11:7]);
  endfunction

  function automatic ex_t captured();
    ex_t c;
    logic [6:0] op;
    op     = ID_IR[6:0];
    c.v    = ID_VALID;
    c.pc   = ID_PC;   c.ir  = ID_IR;
    c.rs1  = ID_RS1;  c.rs2 = ID_RS2;
    c.srca = ID_ALU_SRCA; c.srcb = ID_ALU_SRCB;
    c.fun  = ID_ALU_FUN;  c.wsel = ID_RF_WR_SEL;
    case (op)
      7'h63, 7'h23: c.rw = 1'b0;
      7'h73:        c.rw = ID_VALID && ID_IR[11:7] != 0 && ID_IR[14:12] != 0;
      default:      c.rw = ID_VALID && ID_IR[11:7] != 0;
    endcase
    c.we = ID_VALID && op == 7'h23;
    c.re = ID_VALID && op == 7'h03;
    return c;
  endfunction

  // One clock: check the combinational stall, advance the model, check EX outputs.
  task automatic step();
    ex_t nxt;
    int unsigned nb, nf;
    #2;
    check("id_stall", {31'd0, ID_STALL}, {31'd0, MEM_STALL || (model_hz() && !EX_FLUSH)});
    nb = m_bubbles; nf = m_flushes;
    if (RST) begin nxt = bubble(); nb = 0; nf = 0; end
    else if (MEM_STALL) nxt = m;
    else if (EX_FLUSH) begin nxt = bubble(); nf = nf + 1; end
    else if (model_hz()) begin nxt = bubble(); nb = nb + 1; end
    else nxt = captured();
    @(posedge clk);
    m = nxt; m_bubbles = nb; m_flushes = nf;
    #1;
    check("ex_valid", {31'd0, EX_VALID}, {31'd0, m.v});
    check("ex_pc", EX_PC, m.pc);
    check("ex_ir", EX_IR, m.ir);
    check("ex_rs1", EX_RS1, m.rs1);
    check("ex_rs2", EX_RS2, m.rs2);
    check("ex_ctl", {23'd0, EX_ALU_SRCA, EX_ALU_SRCB, EX_ALU_FUN, EX_RF_WR_SEL},
          {23'd0, m.srca, m.srcb, m.fun, m.wsel});
    check("ex_flags", {29'd0, EX_REG_WR, EX_MEM_WE, EX_MEM_RE}, {29'd0, m.rw, m.we, m.re});
    check("ex_rd", {27'd0, EX_RD}, {27'd0, m.ir[11:7]});
`ifdef OTTER_ID_EX_PERF_EN
    check("perf_bubbles", PERF_BUBBLES, m_bubbles);
    check("perf_flushes", PERF_FLUSHES, m_flushes);
`endif
  endtask

  task automatic feed(input logic v, input logic [31:0] ir, input logic [31:0] pc);
    ID_VALID = v; ID_IR = ir; ID_PC = pc;
    ID_RS1 = $urandom; ID_RS2 = $urandom;
    ID_ALU_SRCA = 1'($urandom); ID_ALU_SRCB = 2'($urandom);
    ID_ALU_FUN = 4'($urandom); ID_RF_WR_SEL = 2'($urandom);
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h73};
    m = bubble(); m_bubbles = 0; m_flushes = 0;
    RST = 1'b1; EX_FLUSH = 1'b0; MEM_STALL = 1'b0;
    feed(1'b1, mk(7'h33, 3, 0, 1, 2), 32'h40);
    @(posedge clk); #1;
    step();
    step();
    check("rst_valid", {31'd0, EX_VALID}, 32'd0);
    check("rst_ir", EX_IR, NOP);
    check("rst_regwr", {31'd0, EX_REG_WR}, 32'd0);
    check("rst_stall", {31'd0, ID_STALL}, 32'd0);
    RST = 1'b0;

    // add x3,x1,x2
    feed(1'b1, 32'h002081B3, 32'h100);
    ID_RS1 = 5; ID_RS2 = 7; ID_ALU_FUN = 4'd0;
    step();
    check("add_pc", EX_PC, 32'h100);
    check("add_rs1", EX_RS1, 32'd5);
    check("add_rs2", EX_RS2, 32'd7);
    check("add_regwr", {31'd0, EX_REG_WR}, 32'd1);
    check("add_rd", {27'd0, EX_RD}, 32'd3);

    // lw x5 then dependent add: one bubble
    feed(1'b1, mk(7'h03, 5, 2, 1, 0), 32'h104);
    step();
    feed(1'b1, mk(7'h33, 6, 0, 5, 2), 32'h108);
    #1 check("lu_stall", {31'd0, ID_STALL}, 32'd1);
    step();
    check("lu_bubble", {31'd0, EX_VALID}, 32'd0);
    #1 check("lu_stall_clr", {31'd0, ID_STALL}, 32'd0);
    step();
    check("lu_add_ir", EX_IR, mk(7'h33, 6, 0, 5, 2));

    // lw x0 never stalls
    feed(1'b1, mk(7'h03, 0, 2, 1, 0), 32'h10c);
    step();
    feed(1'b1, mk(7'h33, 6, 0, 0, 2), 32'h110);
    #1 check("x0_stall", {31'd0, ID_STALL}, 32'd0);
    step();

    // store reading x5 on rs2 stalls; lui x5 does not
    feed(1'b1, mk(7'h03, 5, 2, 1, 0), 32'h114);
    step();
    feed(1'b1, mk(7'h23, 0, 2, 1, 5), 32'h118);
    #1 check("sw_stall", {31'd0, ID_STALL}, 32'd1);
    feed(1'b1, mk(7'h37, 5, 0, 5, 5), 32'h118);
    #1 check("lui_stall", {31'd0, ID_STALL}, 32'd0);
    step();

    // flush overrides load-use stall
    feed(1'b1, mk(7'h03, 5, 2, 1, 0), 32'h11c);
    step();
    feed(1'b1, mk(7'h33, 6, 0, 5, 2), 32'h120);
    EX_FLUSH = 1'b1;
    #1 check("fl_stall", {31'd0, ID_STALL}, 32'd0);
    step();
    check("fl_ir", EX_IR, NOP);
    EX_FLUSH = 1'b0;

    // MEM_STALL with flush pending, then release
    RST = 1'b1; step(); RST = 1'b0;
    feed(1'b1, mk(7'h13, 7, 0, 1, 0), 32'h200);
    step();
    MEM_STALL = 1'b1; EX_FLUSH = 1'b1;
    feed(1'b1, mk(7'h33, 8, 0, 7, 7), 32'h204);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ms_frozen_pc", EX_PC, 32'h200);
    end
    MEM_STALL = 1'b0;
    step();
    check("ms_release_valid", {31'd0, EX_VALID}, 32'd0);
`ifdef OTTER_ID_EX_PERF_EN
    check("ms_flushes", PERF_FLUSHES, 32'd1);
`endif
    EX_FLUSH = 1'b0;

    // randomized traffic with small register numbers to provoke hazards
    for (int c = 0; c < 2000; c++) begin
      feed(($urandom_range(0, 5) != 0),
           mk(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 3)) | ($urandom & 32'hFE000000),
           $urandom);
      MEM_STALL = ($urandom_range(0, 5) == 0);
      EX_FLUSH  = ($urandom_range(0, 7) == 0);
      RST       = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
